// File: rtl/distance_pkg.sv
// Shared constants, FSM encoding and helpers for the
// multi-channel ultrasonic distance converter.
package distance_pkg;

    localparam int CLK_PER_CM_6MHZ = 348;
    localparam int MAX_CM_DEFAULT  = 400;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_DIV  = ST_DIV,
        S_DONE = ST_DONE
    } state_t;

    // ceil(log2(n)); 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/distance_calc_mc_divider.sv
// Fixed-latency restoring divider, one quotient bit per cycle.
// The first bit is produced on the start edge, so done rises W-1 cycles later.
module seq_divider
    import distance_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = clog2(W + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_dvs;

    logic [W-1:0]  w_src_rem;
    logic [W-1:0]  w_src_q;
    logic [W-1:0]  w_src_dvs;
    logic [W:0]    w_trial;
    logic          w_ge;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_q_nxt;

    // One restoring step on either the fresh operands or the running state
    always_comb begin
        w_src_rem = start ? '0 : r_rem;
        w_src_q   = start ? dividend : r_q;
        w_src_dvs = start ? divisor : r_dvs;
        w_trial   = {w_src_rem, w_src_q[W-1]};
        w_ge      = (w_trial >= {1'b0, w_src_dvs});
        w_rem_nxt = w_ge ? (w_trial[W-1:0] - w_src_dvs)
                         : w_trial[W-1:0];
        w_q_nxt   = (w_src_q << 1) | W'(w_ge);
    end

    assign done     = r_busy && (r_cnt == CW'(W));
    assign quotient = r_q;

    // Iteration state: counts steps taken, stops after the W-th
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(1);
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
            r_dvs  <= divisor;
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                r_rem <= w_rem_nxt;
                r_q   <= w_q_nxt;
            end
        end
    end

endmodule

// File: rtl/distance_calc_mc.sv
// Multi-channel echo-width to centimetre converter sharing one
// sequential divider, round-robin across pending channels.
module distance_calc_mc
    import distance_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int ECHO_W     = 24,
    parameter  int DIST_W     = 16,
    parameter  int CLK_PER_CM = CLK_PER_CM_6MHZ,
    parameter  int MAX_CM     = MAX_CM_DEFAULT,
    localparam int CH_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        echo_valid,
    input  logic [NUM_CH*ECHO_W-1:0] echo_cycles,
    output logic [NUM_CH*DIST_W-1:0] distance_cm,
    output logic                     res_valid,
    output logic [CH_W-1:0]          res_ch,
    output logic [DIST_W-1:0]        res_dist,
    output logic                     res_oor,
    output logic [NUM_CH-1:0]        overrun,
    output logic                     busy
);

    localparam logic [ECHO_W-1:0] C_DIVISOR = ECHO_W'(CLK_PER_CM);
    localparam logic [ECHO_W-1:0] C_MAX_Q   = ECHO_W'(MAX_CM);
    localparam logic [DIST_W-1:0] C_MAX_D   = DIST_W'(MAX_CM);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_pend;
    logic [NUM_CH-1:0]   r_overrun;
    logic [NUM_CH-1:0]   w_clr;
    logic [ECHO_W-1:0]   r_hold [NUM_CH];
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     r_cur_ch;
    logic                r_cur_zero;
    logic [CH_W-1:0]     w_gch;
    logic                w_found;
    logic                w_grant;
    logic                w_div_done;
    logic [ECHO_W-1:0]   w_quot;
    logic [DIST_W-1:0]   w_dist;
    logic                w_oor;

    logic [NUM_CH*DIST_W-1:0] r_dist_cm;
    logic                     r_res_valid;
    logic [CH_W-1:0]          r_res_ch;
    logic [DIST_W-1:0]        r_res_dist;
    logic                     r_res_oor;

    // Round-robin pick: first pending channel at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_gch   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && r_pend[(int'(r_ptr) + k) % NUM_CH]) begin
                w_found = 1'b1;
                w_gch   = CH_W'((int'(r_ptr) + k) % NUM_CH);
            end
        end
    end

    // FSM next state; a grant is only issued from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (w_div_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pending-bit clear for the granted channel
    always_comb begin
        w_clr = '0;
        if (w_grant) begin
            w_clr[w_gch] = 1'b1;
        end
    end

    seq_divider #(
        .W (ECHO_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_grant),
        .dividend (r_hold[w_gch]),
        .divisor  (C_DIVISOR),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    // Saturation: zero echo means no target; large quotients clamp
    always_comb begin
        w_dist = DIST_W'(w_quot);
        w_oor  = 1'b0;
        if (r_cur_zero) begin
            w_dist = '0;
            w_oor  = 1'b1;
        end else if (w_quot > C_MAX_Q) begin
            w_dist = C_MAX_D;
            w_oor  = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture, pending/overrun tracking and grant bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_overrun  <= '0;
            r_ptr      <= '0;
            r_cur_ch   <= '0;
            r_cur_zero <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (echo_valid[i]) begin
                    r_hold[i] <= echo_cycles[i*ECHO_W +: ECHO_W];
                    if (r_pend[i] && !w_clr[i]) begin
                        r_overrun[i] <= 1'b1;
                    end
                end
            end
            r_pend <= echo_valid | (r_pend & ~w_clr);
            if (w_grant) begin
                r_cur_ch   <= w_gch;
                r_cur_zero <= (r_hold[w_gch] == '0);
                r_ptr      <= (w_gch == CH_W'(NUM_CH - 1))
                              ? '0 : w_gch + CH_W'(1);
            end
        end
    end

    // Result registers, written on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dist_cm   <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_dist  <= '0;
            r_res_oor   <= 1'b0;
        end else if (r_state == S_DIV && w_div_done) begin
            r_dist_cm[r_cur_ch*DIST_W +: DIST_W] <= w_dist;
            r_res_valid <= 1'b1;
            r_res_ch    <= r_cur_ch;
            r_res_dist  <= w_dist;
            r_res_oor   <= w_oor;
        end else begin
            r_res_valid <= 1'b0;
        end
    end

    assign distance_cm = r_dist_cm;
    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_dist    = r_res_dist;
    assign res_oor     = r_res_oor;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule
